// File: rtl/array_row_feeder.sv
// West-edge feeder for the systolic array: pops per-row FIFOs on a diagonally
// skewed schedule and stalls every row together when any scheduled row is starved.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | stepping the skewed pop schedule, stalling on starved rows
// DONE  | one-cycle tile-end pulse, then back to IDLE
module array_row_feeder #(
   parameter int ROWS       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int K_LEN      = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ROWS-1:0]            fifo_empty,
   input  logic [ROWS*DATA_WIDTH-1:0] fifo_data,
   output logic [ROWS-1:0]            fifo_rd_en,
   output logic [ROWS*DATA_WIDTH-1:0] a_out,
   output logic [ROWS-1:0]            a_valid,
   output logic                       stall,
   output logic                       busy,
   output logic                       done
);

   localparam int SW = $clog2(K_LEN + ROWS);
   localparam logic [SW-1:0] LAST_STEP = SW'(K_LEN + ROWS - 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   logic [SW-1:0]   step;
   logic [ROWS-1:0] sched;
   logic            run;
   logic            advance;

   assign run = (state == RUN);

   // Row r is live for K_LEN steps starting at step r.
   always_comb begin
      sched = '0;
      for (int r = 0; r < ROWS; r++) begin
         sched[r] = run && (32'(step) >= 32'(r)) && (32'(step) < 32'(r + K_LEN));
      end
   end

   assign advance    = run && (&(~sched | ~fifo_empty));
   assign stall      = run && !advance;
   assign fifo_rd_en = sched & {ROWS{advance}};
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         step    <= '0;
         a_out   <= '0;
         a_valid <= '0;
      end else begin
         // Non-popped rows carry zero, so a stall is an all-rows bubble.
         a_valid <= fifo_rd_en;
         for (int r = 0; r < ROWS; r++) begin
            a_out[r*DATA_WIDTH +: DATA_WIDTH] <= fifo_rd_en[r] ?
               fifo_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  step  <= '0;
               end
            end
            RUN: begin
               if (advance) begin
                  if (step == LAST_STEP) begin
                     state <= DONE;
                  end else begin
                     step <= step + 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_array_row_feeder.sv
// Directed bench for array_row_feeder: a K_LEN=4 instance fed by a small FIFO
// model, plus a K_LEN=1 instance with always-full FIFOs.
module tb_array_row_feeder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, start1, fifo_clr;
   logic [3:0]  fifo_empty, rd_en, a_valid, hold;
   logic [31:0] fifo_data, a_out;
   logic        stall, busy, done;

   logic [3:0]  empty1, rd_en1, a_valid1;
   logic [31:0] data1, a_out1;
   logic        stall1, busy1, done1;

   logic [7:0] mem [4][16];
   int wcnt [4];
   int rptr [4];
   int pops [4];
   int bad_pops = 0;
   int n_total = 0;
   int n_pass = 0;

   array_row_feeder #(.ROWS(4), .DATA_WIDTH(8), .K_LEN(4)) dut (
      .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .fifo_rd_en(rd_en), .a_out(a_out),
      .a_valid(a_valid), .stall(stall), .busy(busy), .done(done));

   array_row_feeder #(.ROWS(4), .DATA_WIDTH(8), .K_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .fifo_empty(empty1),
      .fifo_data(data1), .fifo_rd_en(rd_en1), .a_out(a_out1),
      .a_valid(a_valid1), .stall(stall1), .busy(busy1), .done(done1));

   assign empty1 = 4'b0000;
   assign data1  = 32'h3A2A1A0A;

   // First-word fall-through FIFO model; pointers advance on the pop edge.
   always_comb begin
      fifo_empty = '0;
      fifo_data  = '0;
      for (int r = 0; r < 4; r++) begin
         fifo_empty[r]      = hold[r] || (rptr[r] >= wcnt[r]);
         fifo_data[r*8 +: 8] = mem[r][rptr[r] % 16];
      end
   end

   always @(posedge clk) begin
      if (fifo_clr) begin
         for (int r = 0; r < 4; r++) begin
            rptr[r] <= 0;
            pops[r] <= 0;
         end
      end else begin
         for (int r = 0; r < 4; r++) begin
            if (rd_en[r]) begin
               if (fifo_empty[r]) bad_pops <= bad_pops + 1;
               rptr[r] <= rptr[r] + 1;
               pops[r] <= pops[r] + 1;
            end
         end
      end
   end

   typedef struct packed {
      logic [3:0]  av;
      logic [31:0] aout;
      logic [3:0]  rd;
      logic        bsy;
      logic        dn;
      logic        stl;
   } vec_t;

   vec_t nom [9];
   vec_t deg [6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic load(input int n);
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < n; i++) mem[r][i] = 8'(r * 16 + i);
         wcnt[r] = n;
      end
      fifo_clr = 1'b1;
      @(negedge clk);
      fifo_clr = 1'b0;
   endtask

   function automatic int pop_sum();
      return pops[0] + pops[1] + pops[2] + pops[3];
   endfunction

   initial begin
      logic [3:0] prev_av;
      logic       seen;

      // Nominal K_LEN=4: a_out packs {row3,row2,row1,row0}
      nom[0] = '{4'b0000, 32'h00000000, 4'b0001, 1'b1, 1'b0, 1'b0};
      nom[1] = '{4'b0001, 32'h00000000, 4'b0011, 1'b1, 1'b0, 1'b0};
      nom[2] = '{4'b0011, 32'h00001001, 4'b0111, 1'b1, 1'b0, 1'b0};
      nom[3] = '{4'b0111, 32'h00201102, 4'b1111, 1'b1, 1'b0, 1'b0};
      nom[4] = '{4'b1111, 32'h30211203, 4'b1110, 1'b1, 1'b0, 1'b0};
      nom[5] = '{4'b1110, 32'h31221300, 4'b1100, 1'b1, 1'b0, 1'b0};
      nom[6] = '{4'b1100, 32'h32230000, 4'b1000, 1'b1, 1'b0, 1'b0};
      nom[7] = '{4'b1000, 32'h33000000, 4'b0000, 1'b1, 1'b1, 1'b0};
      nom[8] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b0};
      // Degenerate K_LEN=1 with constant heads 0x0A/0x1A/0x2A/0x3A
      deg[0] = '{4'b0000, 32'h00000000, 4'b0001, 1'b1, 1'b0, 1'b0};
      deg[1] = '{4'b0001, 32'h0000000A, 4'b0010, 1'b1, 1'b0, 1'b0};
      deg[2] = '{4'b0010, 32'h00001A00, 4'b0100, 1'b1, 1'b0, 1'b0};
      deg[3] = '{4'b0100, 32'h002A0000, 4'b1000, 1'b1, 1'b0, 1'b0};
      deg[4] = '{4'b1000, 32'h3A000000, 4'b0000, 1'b1, 1'b1, 1'b0};
      deg[5] = '{4'b0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; start = 1'b0; start1 = 1'b0; hold = '0; fifo_clr = 1'b1;
      for (int r = 0; r < 4; r++) wcnt[r] = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0; fifo_clr = 1'b0;
      @(negedge clk);
      chk("rst_a_valid", 32'(a_valid), 0);
      chk("rst_a_out", a_out, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_stall", 32'(stall), 0);

      // Nominal tile
      load(4);
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("nom_c%0d_av", c), 32'(a_valid), 32'(nom[c].av));
         chk($sformatf("nom_c%0d_aout", c), a_out, nom[c].aout);
         chk($sformatf("nom_c%0d_rd", c), 32'(rd_en), 32'(nom[c].rd));
         chk($sformatf("nom_c%0d_busy", c), 32'(busy), 32'(nom[c].bsy));
         chk($sformatf("nom_c%0d_done", c), 32'(done), 32'(nom[c].dn));
         chk($sformatf("nom_c%0d_stall", c), 32'(stall), 32'(nom[c].stl));
      end

      // Starvation: row 2 empty for cycles 2..4
      load(4);
      hold[2] = 1'b1;
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("stv_c%0d_stall", c), 32'(stall), 32'(c >= 2 && c <= 4));
         if (c >= 2 && c <= 4) chk($sformatf("stv_c%0d_rd", c), 32'(rd_en), 0);
         if (c >= 3 && c <= 5) chk($sformatf("stv_c%0d_bubble", c), 32'(a_valid), 0);
         if (c == 6) begin
            chk("stv_row2_first_v", 32'(a_valid[2]), 1);
            chk("stv_row2_first_d", 32'(a_out[23:16]), 32'h20);
         end
         if (c >= 7 && c <= 10) begin
            chk($sformatf("stv_c%0d_r3v", c), 32'(a_valid[3]), 1);
            chk($sformatf("stv_c%0d_r3d", c), 32'(a_out[31:24]), 32'(8'h30 + c - 7));
         end
         chk($sformatf("stv_c%0d_done", c), 32'(done), 32'(c == 10));
         if (c == 4) begin
            @(posedge clk);
            #1 hold[2] = 1'b0;
         end
      end

      // start while busy is ignored; start in the IDLE cycle after DONE works
      load(8);
      start = 1'b1; @(negedge clk); start = 1'b0;
      for (int c = 1; c < 10; c++) begin
         @(negedge clk);
         if (c == 2) start = 1'b1;
         if (c == 3) start = 1'b0;
         if (c == 7) begin
            chk("sb_c7_done", 32'(done), 1);
            start = 1'b1;
         end
         if (c == 8) begin
            chk("sb_c8_busy", 32'(busy), 0);
            chk("sb_c8_pops", 32'(pop_sum()), 16);
         end
         if (c == 9) begin
            start = 1'b0;
            chk("sb_c9_busy", 32'(busy), 1);
            chk("sb_c9_rd", 32'(rd_en), 32'b0001);
            chk("sb_c9_av", 32'(a_valid), 0);
         end
      end
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("sb_tile2_done", 32'(seen), 1);
      @(negedge clk);
      chk("sb_tile2_pops", 32'(pop_sum()), 32);

      // Reset at step 3
      load(4);
      start = 1'b1; @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mr_a_valid", 32'(a_valid), 0);
      chk("mr_a_out", a_out, 0);
      chk("mr_busy", 32'(busy), 0);
      chk("mr_done", 32'(done), 0);
      chk("mr_rd", 32'(rd_en), 0);
      chk("mr_stall", 32'(stall), 0);
      rst = 1'b0;
      for (int r = 0; r < 4; r++) chk($sformatf("mr_pops_r%0d", r), 32'(pops[r]), 32'(4 - r));
      repeat (5) @(negedge clk);
      chk("mr_pops_after", 32'(pop_sum()), 10);
      chk("mr_idle_busy", 32'(busy), 0);

      // Degenerate K_LEN=1
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      prev_av = '0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("deg_c%0d_av", c), 32'(a_valid1), 32'(deg[c].av));
         chk($sformatf("deg_c%0d_aout", c), a_out1, deg[c].aout);
         chk($sformatf("deg_c%0d_rd", c), 32'(rd_en1), 32'(deg[c].rd));
         chk($sformatf("deg_c%0d_busy", c), 32'(busy1), 32'(deg[c].bsy));
         chk($sformatf("deg_c%0d_done", c), 32'(done1), 32'(deg[c].dn));
         chk($sformatf("deg_c%0d_noconsec", c), 32'(prev_av & a_valid1), 0);
         prev_av = a_valid1;
      end

      chk("pop_on_empty", 32'(bad_pops), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
